// File: rtl/blk_404638.sv
// -----------------------------------------------------------------------------
// blk_404638 : manycore link response-path adapter, credit side <-> ready/and
//
// Converts the response (rev) sub-link coming from a credit-based endpoint into
// a ready/and handshake toward the network. Responses from the credit side are
// pushed into a small FIFO unconditionally. The credit side may only send as
// many responses as it holds credits, and it starts with fifo_els_p credits.
// Each response popped toward the network returns one credit as a single-cycle
// registered pulse on credit_link_sif_o.rev.ready_and_rev.
//
// The forward (request) sub-link is a pure wire-through in both directions.
// The response sub-link from the ready/and side is also a wire-through,
// except for its ready_and_rev bit, which carries the credit pulse.
//
// Parameters
//   addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p
//        Manycore geometry. The defaults are only placeholders for lint.
//        Set them for the target system.
//   fifo_els_p
//        Response buffer depth (>= 2). Also the number of credits owned by
//        the credit-side endpoint.
//   assert_overflow_p
//        Set to 1 to enable the simulation-time overflow error.
//
// Ports
//   clk_i                 clock
//   reset_i               asynchronous active-high reset
//   credit_link_sif_i     link from the credit-based endpoint
//   credit_link_sif_o     link to the credit-based endpoint
//   ready_and_link_sif_i  link from the ready/and network
//   ready_and_link_sif_o  link to the ready/and network
//
// Link layout (MSB first), bsg_manycore_link_sif_s:
//   fwd { v, request packet, ready_and_rev }
//   rev { v, return packet,  ready_and_rev }
// Packet widths:
//   request packet = addr + data + 2*(x + y) + op(2) + op_ex(4) + reg_id(5)
//   return packet  = type(2) + data + reg_id(5) + x + y
// -----------------------------------------------------------------------------
module blk_404638 #(
   parameter int addr_width_p      = 32,
   parameter int data_width_p      = 32,
   parameter int x_cord_width_p    = 7,
   parameter int y_cord_width_p    = 7,
   parameter int fifo_els_p        = 3,
   parameter bit assert_overflow_p = 1'b1,
   // Derived widths; not meant to be overridden.
   parameter int fwd_pkt_w_lp = addr_width_p + data_width_p
                              + 2*(x_cord_width_p + y_cord_width_p) + 2 + 4 + 5,
   parameter int ret_pkt_w_lp = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p,
   parameter int fwd_w_lp     = fwd_pkt_w_lp + 2,
   parameter int rev_w_lp     = ret_pkt_w_lp + 2,
   parameter int link_w_lp    = fwd_w_lp + rev_w_lp
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [link_w_lp-1:0] credit_link_sif_i,
   output logic [link_w_lp-1:0] credit_link_sif_o,
   input  logic [link_w_lp-1:0] ready_and_link_sif_i,
   output logic [link_w_lp-1:0] ready_and_link_sif_o
);

   localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

   // ---------------------------------------------------------------------------
   // Field unpacking. The rev sub-link occupies the low bits of the link.
   // ---------------------------------------------------------------------------
   logic [fwd_w_lp-1:0]     cr_fwd_in;
   logic [fwd_w_lp-1:0]     ra_fwd_in;
   logic                    cr_rev_v;
   logic [ret_pkt_w_lp-1:0] cr_rev_data;
   logic                    cr_rev_ready;
   logic                    ra_rev_v;
   logic [ret_pkt_w_lp-1:0] ra_rev_data;
   logic                    ra_rev_ready;

   assign cr_fwd_in    = credit_link_sif_i[link_w_lp-1:rev_w_lp];
   assign ra_fwd_in    = ready_and_link_sif_i[link_w_lp-1:rev_w_lp];
   assign cr_rev_v     = credit_link_sif_i[rev_w_lp-1];
   assign cr_rev_data  = credit_link_sif_i[rev_w_lp-2:1];
   assign cr_rev_ready = credit_link_sif_i[0];
   assign ra_rev_v     = ready_and_link_sif_i[rev_w_lp-1];
   assign ra_rev_data  = ready_and_link_sif_i[rev_w_lp-2:1];
   assign ra_rev_ready = ready_and_link_sif_i[0];

   // ---------------------------------------------------------------------------
   // Response FIFO state
   // ---------------------------------------------------------------------------
   logic [ret_pkt_w_lp-1:0] mem [fifo_els_p];
   logic [ptr_w_lp-1:0]     wr_ptr_reg;
   logic [ptr_w_lp-1:0]     rd_ptr_reg;
   logic [cnt_w_lp-1:0]     count_reg;
   logic                    credit_reg;

   logic                    empty;
   logic                    full;
   logic                    enq;
   logic                    deq;
   logic                    overflow;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == full_cnt_lp);

   // The head is popped when it is offered and the network accepts it.
   assign deq = ~empty & ra_rev_ready;

   // A push is accepted whenever there is room. On a full FIFO that room
   // comes from a same-cycle pop. A push with no room means the endpoint
   // sent more responses than it had credits. That packet is dropped.
   assign enq      = cr_rev_v & (~full | deq);
   assign overflow = cr_rev_v & full & ~deq;

   // Storage is written without reset. Reset only needs to clear the
   // pointers and the count, which keeps this an array-style RAM.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem[wr_ptr_reg] <= cr_rev_data;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         credit_reg <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_reg <= (wr_ptr_reg == last_ptr_lp) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (deq) begin
            rd_ptr_reg <= (rd_ptr_reg == last_ptr_lp) ? '0 : rd_ptr_reg + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         // One credit per popped response, returned the following cycle.
         credit_reg <= deq;
      end
   end

   // Simulation-only check for a credit protocol violation.
   always_ff @(posedge clk_i) begin
      if (assert_overflow_p && !reset_i) begin
         assert (!overflow)
            else $error("blk_404638: response pushed into full buffer without credit");
      end
   end

   // ---------------------------------------------------------------------------
   // Output assembly
   // ---------------------------------------------------------------------------
   // There is no bypass. The head is read from storage, so a packet pushed
   // in cycle t first appears in cycle t+1.
   assign ready_and_link_sif_o = {cr_fwd_in, ~empty, mem[rd_ptr_reg], cr_rev_ready};
   assign credit_link_sif_o    = {ra_fwd_in, ra_rev_v, ra_rev_data, credit_reg};

endmodule

// File: tb/tb_blk_404638.sv
module tb_blk_404638;

   localparam int AW = 8, DW = 8, XW = 2, YW = 2, ELS = 3;
   localparam int FWD_PKT = AW + DW + 2*(XW + YW) + 11;   // 35
   localparam int RET_PKT = 2 + DW + 5 + XW + YW;         // 19
   localparam int FWD_W   = FWD_PKT + 2;                  // 37
   localparam int REV_W   = RET_PKT + 2;                  // 21
   localparam int LINK_W  = FWD_W + REV_W;                // 58

   logic              clk = 1'b0;
   logic              rst;
   logic [LINK_W-1:0] cr_i, cr_o, ra_i, ra_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   blk_404638 #(
      .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW),
      .y_cord_width_p(YW), .fifo_els_p(ELS), .assert_overflow_p(1'b0)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .credit_link_sif_i(cr_i), .credit_link_sif_o(cr_o),
      .ready_and_link_sif_i(ra_i), .ready_and_link_sif_o(ra_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the response half of the credit-side input.
   task automatic push(input logic v, input logic [RET_PKT-1:0] d);
      cr_i[REV_W-1]   = v;
      cr_i[REV_W-2:1] = d;
   endtask

   task automatic set_ready(input logic r);
      ra_i[0] = r;
   endtask

   function automatic logic out_v();
      return ra_o[REV_W-1];
   endfunction

   function automatic logic [RET_PKT-1:0] out_d();
      return ra_o[REV_W-2:1];
   endfunction

   function automatic logic credit();
      return cr_o[0];
   endfunction

   initial begin
      cr_i = '0;
      ra_i = '0;
      rst  = 1'b1;
      tick();
      tick();
      chk("reset_v", out_v(), 0);
      chk("reset_credit", credit(), 0);
      rst = 1'b0;
      tick();

      // One packet in, popped as soon as it shows, then one credit.
      push(1, 19'h0A5);
      set_ready(1);
      #1 chk("nobypass_v", out_v(), 0);
      tick();
      push(0, 0);
      #1;
      chk("single_v", out_v(), 1);
      chk("single_d", out_d(), 19'h0A5);
      chk("single_credit_early", credit(), 0);
      tick();
      chk("single_credit", credit(), 1);
      chk("single_empty", out_v(), 0);
      tick();
      chk("single_credit_once", credit(), 0);

      // Fill to three with the network stalled, then drain.
      set_ready(0);
      for (int i = 1; i <= 3; i++) begin
         push(1, 19'(i));
         tick();
         chk("fill_credit", credit(), 0);
      end
      push(0, 0);
      tick();
      tick();
      chk("stall_v", out_v(), 1);
      chk("stall_head", out_d(), 1);
      chk("stall_credit", credit(), 0);
      set_ready(1);
      #1 chk("drain_d1", out_d(), 1);
      tick();
      chk("drain_credit1", credit(), 1);
      chk("drain_d2", out_d(), 2);
      tick();
      chk("drain_credit2", credit(), 1);
      chk("drain_d3", out_d(), 3);
      tick();
      chk("drain_credit3", credit(), 1);
      chk("drain_empty", out_v(), 0);
      tick();
      chk("drain_credit_end", credit(), 0);

      // Full buffer: a push and a pop in the same cycle.
      set_ready(0);
      for (int i = 1; i <= 3; i++) begin
         push(1, 19'(i));
         tick();
      end
      push(1, 19'd4);
      set_ready(1);
      #1;
      chk("fullpp_no_overflow", dut.overflow, 0);
      chk("fullpp_head", out_d(), 1);
      tick();
      push(0, 0);
      #1;
      chk("fullpp_d2", out_d(), 2);
      tick();
      chk("fullpp_d3", out_d(), 3);
      tick();
      chk("fullpp_d4", out_d(), 4);
      chk("fullpp_v4", out_v(), 1);
      tick();
      chk("fullpp_empty", out_v(), 0);
      tick();

      // Full buffer with the network stalled: the extra packet is dropped.
      set_ready(0);
      for (int i = 1; i <= 3; i++) begin
         push(1, 19'(i));
         tick();
      end
      push(1, 19'd9);
      #1 chk("ovf_flag", dut.overflow, 1);
      tick();
      push(0, 0);
      set_ready(1);
      #1 chk("ovf_d1", out_d(), 1);
      tick();
      chk("ovf_d2", out_d(), 2);
      tick();
      chk("ovf_d3", out_d(), 3);
      tick();
      chk("ovf_empty", out_v(), 0);
      tick();

      // Pass-through paths with random content.
      for (int i = 0; i < 6; i++) begin
         logic [63:0] r1, r2, r3;
         r1 = {$urandom, $urandom};
         r2 = {$urandom, $urandom};
         r3 = {$urandom, $urandom};
         cr_i[LINK_W-1:REV_W] = r1[FWD_W-1:0];
         cr_i[0]              = r3[0];
         ra_i                 = r2[LINK_W-1:0];
         ra_i[0]              = 1'b0;
         #2;
         chk("pt_cr_to_ra_fwd", 64'(ra_o[LINK_W-1:REV_W]), 64'(r1[FWD_W-1:0]));
         chk("pt_ra_to_cr_fwd", 64'(cr_o[LINK_W-1:REV_W]), 64'(r2[LINK_W-1:REV_W]));
         chk("pt_ra_to_cr_rev", 64'(cr_o[REV_W-1:1]), 64'(r2[REV_W-1:1]));
         chk("pt_ready_rev", ra_o[0], r3[0]);
      end
      cr_i = '0;
      ra_i = '0;
      tick();

      // Reset in the middle of operation with two packets buffered.
      for (int i = 1; i <= 2; i++) begin
         push(1, 19'(i + 16));
         tick();
      end
      push(0, 0);
      #1 chk("pre_reset_v", out_v(), 1);
      #1 rst = 1'b1;
      #1 chk("async_reset_v", out_v(), 0);
      push(1, 19'h77);
      set_ready(1);
      tick();
      tick();
      chk("in_reset_v", out_v(), 0);
      chk("in_reset_credit", credit(), 0);
      push(0, 0);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_reset_credit", credit(), 0);
         chk("post_reset_v", out_v(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety bound so the bench always ends on its own.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
